// File: rtl/debug_text_pkg.sv
// Shared text-overlay definitions: ASCII constants and the nibble-to-ASCII
// mapping used by the hex encoders of the debugger status line.
package debug_text_pkg;

    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_A_UP  = 8'h41;
    localparam logic [7:0] CH_A_LO  = 8'h61;

    localparam int MAX_NIBBLES = 8;

    // Maps one hex digit to its ASCII code; letters follow the case flag.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib, input logic upper);
        logic [7:0] code;
        logic [7:0] letter_base;
        letter_base = upper ? CH_A_UP : CH_A_LO;
        if (nib < 4'd10) begin
            code = CH_ZERO + {4'd0, nib};
        end else begin
            code = letter_base + {4'd0, nib - 4'd10};
        end
        return code;
    endfunction

endpackage

// File: rtl/hex_digit_enc.sv
// Combinational single-digit hex encoder: one 4-bit digit in, one ASCII byte out.
module hex_digit_enc
    import debug_text_pkg::*;
#(
    parameter int UPPERCASE = 1
) (
    input  logic [3:0] digit,
    output logic [7:0] ascii
);

    localparam logic UPPER_FLAG = (UPPERCASE != 0);

    // Digit-to-character lookup.
    always_comb begin
        ascii = nibble_to_ascii(digit, UPPER_FLAG);
    end

endmodule

// File: rtl/int_to_hex_unit.sv
// Registered binary-to-ASCII hex converter with optional leading-zero blanking,
// plus an unregistered view of the same encoding.
module int_to_hex_unit
    import debug_text_pkg::*;
#(
    parameter int NIBBLES   = 1,
    parameter int UPPERCASE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [4*NIBBLES-1:0]   in_value,
    input  logic                   blank_lz,
    output logic                   out_valid,
    output logic [8*NIBBLES-1:0]   out_chars,
    output logic [8*NIBBLES-1:0]   out_comb
);

    logic [8*NIBBLES-1:0] raw_chars;
    logic [8*NIBBLES-1:0] enc_chars;
    logic [8*NIBBLES-1:0] out_chars_d;
    logic [8*NIBBLES-1:0] out_chars_q;
    logic                 out_valid_d;
    logic                 out_valid_q;

    for (genvar i = 0; i < NIBBLES; i++) begin : g_digit
        hex_digit_enc #(
            .UPPERCASE (UPPERCASE)
        ) u_enc (
            .digit (in_value[4*i +: 4]),
            .ascii (raw_chars[8*i +: 8])
        );
    end

    // Leading-zero blanking: walk from the top digit down; a digit is blanked
    // only while no nonzero digit has been seen above it. Digit 0 always shows.
    always_comb begin
        logic seen_nz;
        seen_nz   = 1'b0;
        enc_chars = '0;
        for (int i = NIBBLES - 1; i >= 0; i--) begin
            seen_nz = seen_nz | (in_value[4*i +: 4] != 4'd0);
            if (blank_lz && !seen_nz && (i != 0)) begin
                enc_chars[8*i +: 8] = CH_SPACE;
            end else begin
                enc_chars[8*i +: 8] = raw_chars[8*i +: 8];
            end
        end
    end

    // Next-state for the output registers: capture on valid, hold otherwise.
    always_comb begin
        out_chars_d = out_chars_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            out_chars_d = enc_chars;
        end else begin
            out_chars_d = out_chars_q;
        end
    end

    // Output registers with asynchronous reset to all-"0" characters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_chars_q <= {NIBBLES{CH_ZERO}};
            out_valid_q <= 1'b0;
        end else begin
            out_chars_q <= out_chars_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_chars = out_chars_q;
    assign out_valid = out_valid_q;
    assign out_comb  = enc_chars;

endmodule

// File: tb/tb_int_to_hex_unit.sv
// Directed self-checking bench for int_to_hex_unit: a 4-digit upper-case
// instance plus single-digit upper- and lower-case instances.
module tb_int_to_hex_unit;

    logic        clk;
    logic        rst;

    logic        iv4;
    logic [15:0] val4;
    logic        blz4;
    logic        ov4;
    logic [31:0] oc4;
    logic [31:0] ocb4;

    logic        ivu;
    logic [3:0]  valu;
    logic        blzu;
    logic        ovu;
    logic [7:0]  ocu;
    logic [7:0]  ocbu;

    logic        ivl;
    logic [3:0]  vall;
    logic        blzl;
    logic        ovl;
    logic [7:0]  ocl;
    logic [7:0]  ocbl;

    int checks;
    int passed;

    int_to_hex_unit #(.NIBBLES(4), .UPPERCASE(1)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_value(val4), .blank_lz(blz4),
        .out_valid(ov4), .out_chars(oc4), .out_comb(ocb4)
    );

    int_to_hex_unit #(.NIBBLES(1), .UPPERCASE(1)) u_dut1u (
        .clk(clk), .rst(rst), .in_valid(ivu), .in_value(valu), .blank_lz(blzu),
        .out_valid(ovu), .out_chars(ocu), .out_comb(ocbu)
    );

    int_to_hex_unit #(.NIBBLES(1), .UPPERCASE(0)) u_dut1l (
        .clk(clk), .rst(rst), .in_valid(ivl), .in_value(vall), .blank_lz(blzl),
        .out_valid(ovl), .out_chars(ocl), .out_comb(ocbl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic beat4(input logic v, input logic [15:0] val, input logic blz);
        @(negedge clk);
        iv4  = v;
        val4 = val;
        blz4 = blz;
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string name, input logic exp_v, input logic [31:0] exp_c);
        checks++;
        if (ov4 !== exp_v || oc4 !== exp_c) begin
            $display("FAIL %s: out_valid=%0b out_chars=%h, expected out_valid=%0b out_chars=%h",
                     name, ov4, oc4, exp_v, exp_c);
        end else begin
            passed++;
        end
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        #2;
        chk4("reset_n4", 1'b0, 32'h30303030);
        checks++;
        if (ovu !== 1'b0 || ocu !== 8'h30 || ovl !== 1'b0 || ocl !== 8'h30) begin
            $display("FAIL reset_n1: u=%0b/%h l=%0b/%h, expected 0/30", ovu, ocu, ovl, ocl);
        end else begin
            passed++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_digit;
        logic [7:0] exp_c;
        for (int d = 0; d < 16; d++) begin
            @(negedge clk);
            ivu  = 1'b1;
            valu = d[3:0];
            blzu = 1'b0;
            @(posedge clk);
            #1;
            exp_c = (d < 10) ? (8'h30 + 8'(d)) : (8'h41 + 8'(d - 10));
            checks++;
            if (ovu !== 1'b1 || ocu !== exp_c) begin
                $display("FAIL digit_%0d: out_valid=%0b out_chars=%h, expected 1/%h", d, ovu, ocu, exp_c);
            end else begin
                passed++;
            end
        end
        @(negedge clk);
        ivu = 1'b0;
    endtask

    task automatic test_lowercase;
        logic [3:0] vals [2];
        logic [7:0] exps [2];
        vals[0] = 4'hB; exps[0] = 8'h62;
        vals[1] = 4'h9; exps[1] = 8'h39;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            ivl  = 1'b1;
            vall = vals[k];
            blzl = 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if (ovl !== 1'b1 || ocl !== exps[k]) begin
                $display("FAIL lower_%h: out_valid=%0b out_chars=%h, expected 1/%h", vals[k], ovl, ocl, exps[k]);
            end else begin
                passed++;
            end
        end
        @(negedge clk);
        ivl = 1'b0;
    endtask

    task automatic test_blanking;
        beat4(1'b1, 16'h0150, 1'b0);
        chk4("0150_noblank", 1'b1, 32'h30313530);
        beat4(1'b1, 16'h0150, 1'b1);
        chk4("0150_blank", 1'b1, 32'h20313530);
        beat4(1'b1, 16'h0000, 1'b1);
        chk4("0000_blank", 1'b1, 32'h20202030);
        @(negedge clk);
        iv4  = 1'b0;
        val4 = 16'h0000;
        blz4 = 1'b0;
        #1;
        checks++;
        if (ocb4 !== 32'h30303030) begin
            $display("FAIL comb_0000: out_comb=%h, expected 30303030", ocb4);
        end else begin
            passed++;
        end
    endtask

    task automatic test_reset_midstream;
        beat4(1'b1, 16'hDEAD, 1'b0);
        chk4("dead", 1'b1, 32'h44454144);
        beat4(1'b1, 16'hBEEF, 1'b0);
        chk4("beef", 1'b1, 32'h42454546);
        val4 = 16'h1234;
        #2 rst = 1'b1;
        #1;
        chk4("async_reset", 1'b0, 32'h30303030);
        @(posedge clk);
        #1;
        chk4("beat_dropped_in_reset", 1'b0, 32'h30303030);
        @(negedge clk);
        rst = 1'b0;
        beat4(1'b1, 16'h0C0A, 1'b1);
        chk4("after_reset", 1'b1, 32'h20433041);
    endtask

    task automatic test_valid_gating;
        beat4(1'b1, 16'h0012, 1'b0);
        chk4("gate_12", 1'b1, 32'h30303132);
        @(negedge clk);
        iv4  = 1'b0;
        val4 = 16'h0034;
        #1;
        checks++;
        if (ocb4 !== 32'h30303334 || oc4 !== 32'h30303132) begin
            $display("FAIL comb_34: out_comb=%h out_chars=%h, expected 30303334/30303132", ocb4, oc4);
        end else begin
            passed++;
        end
        @(posedge clk);
        #1;
        chk4("gate_hold", 1'b0, 32'h30303132);
    endtask

    task automatic test_back_to_back;
        beat4(1'b1, 16'hFFFF, 1'b0);
        chk4("b2b_ffff", 1'b1, 32'h46464646);
        beat4(1'b1, 16'h0001, 1'b0);
        chk4("b2b_0001", 1'b1, 32'h30303031);
        beat4(1'b1, 16'hA5C3, 1'b0);
        chk4("b2b_a5c3", 1'b1, 32'h41354333);
        beat4(1'b0, 16'h0000, 1'b0);
        chk4("b2b_idle", 1'b0, 32'h41354333);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst  = 1'b0;
        iv4  = 1'b0; val4 = 16'h0000; blz4 = 1'b0;
        ivu  = 1'b0; valu = 4'h0;     blzu = 1'b0;
        ivl  = 1'b0; vall = 4'h0;     blzl = 1'b0;
        test_reset;
        test_single_digit;
        test_lowercase;
        test_blanking;
        test_reset_midstream;
        test_valid_gating;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
